// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared widths, data constants and fetch state encoding
// Purpose: common definitions imported by the fetcher top and its icache.
// Ports: none (package).
package fetcher_pkg;

  localparam int INS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [INS_WIDTH-1:0] ZERO_DATA = '0;

  // RUN : looking up / issuing from the cache
  // MISS: waiting for memory to return the word at pc
  // DROP: a flush arrived mid-miss; memory cannot abort, so the word is
  //       still filled into the cache but never issued
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MISS = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [ADDR_WIDTH-1:0] pc_plus4(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped instruction cache, one word per line
// Purpose: tag/data/valid storage with combinational lookup and a synchronous
//          fill port. Valid bits clear asynchronously on rst.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rd_addr            lookup byte address (low two bits ignored)
//   rd_hit, rd_data    combinational hit flag and line data
//   wr_en              fill strobe
//   wr_addr, wr_data   fill byte address and word
module fetcher_icache
  import fetcher_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_hit,
  output logic [INS_WIDTH-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [INS_WIDTH-1:0]  wr_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [INS_WIDTH-1:0] data_mem [LINES];
  logic [LINES-1:0]     valid;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_addr[IDX_W+1:2];
  assign rd_tag = rd_addr[ADDR_WIDTH-1:IDX_W+2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_tag = wr_addr[ADDR_WIDTH-1:IDX_W+2];

  // Byte offset bits are always zero for word fetches.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{rd_addr[1:0], wr_addr[1:0]};

  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch unit feeding the decoder
// Purpose: holds the PC, looks it up in the icache, fetches misses from
//          memory and issues one instruction per cycle (static not-taken).
// Ports:
//   clk_in, rst_in, rdy_in              clock, async active-high reset, global ready
//   rob_full, rs_full                   downstream stalls
//   rob2fetch_flush/_target_pc          redirect pulse and new PC
//   fetch2mem_enable/_addr              word fetch request (level)
//   mem2fetch_done/_ins                 fetch completion pulse and data
//   fetch2decoder_enable/_ins/_pc       issued instruction (one-cycle pulse)
module fetcher
  import fetcher_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 32'h0,
  parameter int                    ICACHE_LINES = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_full,
  input  logic                  rs_full,
  input  logic                  rob2fetch_flush,
  input  logic [ADDR_WIDTH-1:0] rob2fetch_target_pc,
  output logic                  fetch2mem_enable,
  output logic [ADDR_WIDTH-1:0] fetch2mem_addr,
  input  logic                  mem2fetch_done,
  input  logic [INS_WIDTH-1:0]  mem2fetch_ins,
  output logic                  fetch2decoder_enable,
  output logic [INS_WIDTH-1:0]  fetch2decoder_ins,
  output logic [ADDR_WIDTH-1:0] fetch2decoder_pc
);

  fetch_state_e          state, state_d;
  logic [ADDR_WIDTH-1:0] pc, pc_d;
  logic                  mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  dec_en_d;
  logic [INS_WIDTH-1:0]  dec_ins_d;
  logic [ADDR_WIDTH-1:0] dec_pc_d;
  logic                  fill;
  logic                  hit;
  logic [INS_WIDTH-1:0]  hit_data;
  logic                  stall;

  assign stall = rob_full | rs_full;

  // Fill uses the outstanding request address, not pc: in DROP the pc has
  // already moved to the flush target.
  fetcher_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk     (clk_in),
    .rst     (rst_in),
    .rd_addr (pc),
    .rd_hit  (hit),
    .rd_data (hit_data),
    .wr_en   (fill),
    .wr_addr (fetch2mem_addr),
    .wr_data (mem2fetch_ins)
  );

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    mem_en_d   = fetch2mem_enable;
    mem_addr_d = fetch2mem_addr;
    dec_en_d   = 1'b0;
    dec_ins_d  = fetch2decoder_ins;
    dec_pc_d   = fetch2decoder_pc;
    fill       = 1'b0;

    // Not ready: everything holds except the issue pulse, which is cleared so
    // an already-seen instruction is not presented twice after the freeze.
    if (rdy_in) begin
      if (state != ST_RUN && mem2fetch_done) begin
        fill     = 1'b1;
        mem_en_d = 1'b0;
        state_d  = ST_RUN;
      end

      if (rob2fetch_flush) begin
        pc_d = rob2fetch_target_pc;
        if (state == ST_MISS && !mem2fetch_done) begin
          state_d = ST_DROP;
        end
      end else if (state == ST_RUN) begin
        if (!hit) begin
          state_d    = ST_MISS;
          mem_en_d   = 1'b1;
          mem_addr_d = pc;
        end else if (!stall) begin
          dec_en_d  = 1'b1;
          dec_ins_d = hit_data;
          dec_pc_d  = pc;
          pc_d      = pc_plus4(pc);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                <= ST_RUN;
      pc                   <= RESET_PC;
      fetch2mem_enable     <= 1'b0;
      fetch2mem_addr       <= '0;
      fetch2decoder_enable <= 1'b0;
      fetch2decoder_ins    <= ZERO_DATA;
      fetch2decoder_pc     <= '0;
    end else begin
      state                <= state_d;
      pc                   <= pc_d;
      fetch2mem_enable     <= mem_en_d;
      fetch2mem_addr       <= mem_addr_d;
      fetch2decoder_enable <= dec_en_d;
      fetch2decoder_ins    <= dec_ins_d;
      fetch2decoder_pc     <= dec_pc_d;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - self-checking bench for the fetcher
module tb_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_full;
  logic        rs_full;
  logic        flush;
  logic [31:0] target_pc;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        done;
  logic [31:0] mem_ins;
  logic        dec_en;
  logic [31:0] dec_ins;
  logic [31:0] dec_pc;

  always #5 clk_in = ~clk_in;

  fetcher #(
    .RESET_PC     (32'h0),
    .ICACHE_LINES (16)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .rob_full             (rob_full),
    .rs_full              (rs_full),
    .rob2fetch_flush      (flush),
    .rob2fetch_target_pc  (target_pc),
    .fetch2mem_enable     (mem_en),
    .fetch2mem_addr       (mem_addr),
    .mem2fetch_done       (done),
    .mem2fetch_ins        (mem_ins),
    .fetch2decoder_enable (dec_en),
    .fetch2decoder_ins    (dec_ins),
    .fetch2decoder_pc     (dec_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  int          issued = 0;
  int          issue_cyc = 0;

  int          mem_cnt = 0;
  logic        prev_en = 1'b0;
  int          req_cnt = 0;
  logic [31:0] last_req_addr = '0;

  typedef struct {
    logic [31:0] target;
    int          n_issue;
    int          exp_reqs;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h13 + (a << 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model (3-cycle latency) and issue scoreboard, sampled 1ns after the edge.
  always @(posedge clk_in) begin
    #1;
    cycle++;
    if (rst_in) begin
      done    = 1'b0;
      mem_cnt = 0;
      prev_en = 1'b0;
    end else begin
      if (dec_en) begin
        issued++;
        issue_cyc = cycle;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_issue: got pc %h expected no issue", dec_pc);
        end else begin
          sb_e = exp_q.pop_front();
          check("issue_pc", dec_pc, sb_e);
          check("issue_ins", dec_ins, mem_word(sb_e));
        end
      end
      if (mem_en && !prev_en) begin
        req_cnt++;
        last_req_addr = mem_addr;
      end
      prev_en = mem_en;
      if (done) begin
        done = 1'b0;
      end else if (mem_en) begin
        mem_cnt++;
        if (mem_cnt == 3) begin
          check("mem_addr_stable", mem_addr, last_req_addr);
          done    = 1'b1;
          mem_ins = mem_word(mem_addr);
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic wait_issues(input int goal);
    int b = 0;
    while (issued < goal && b < 200) begin
      @(negedge clk_in);
      b++;
    end
    if (issued < goal) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got %0d issues expected %0d", issued, goal);
    end
  endtask

  task automatic wait_req(input int goal);
    int b = 0;
    while (req_cnt < goal && b < 200) begin
      @(negedge clk_in);
      b++;
    end
    if (req_cnt < goal) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got %0d requests expected %0d", req_cnt, goal);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    repeat (2) @(negedge clk_in);
    while (mem_en && b < 200) begin
      @(negedge clk_in);
      b++;
    end
    if (mem_en) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got enable %b expected 0", mem_en);
    end
  endtask

  task automatic start_flush(input logic [31:0] t);
    flush     = 1'b1;
    target_pc = t;
    rob_full  = 1'b0;
    @(negedge clk_in);
    flush     = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int r0;
    int goal;
    wait_idle();
    r0   = req_cnt;
    goal = issued + vecs[idx].n_issue;
    for (int i = 0; i < vecs[idx].n_issue; i++) exp_q.push_back(vecs[idx].target + 32'(4 * i));
    start_flush(vecs[idx].target);
    wait_issues(goal);
    rob_full = 1'b1;
    check($sformatf("vec%0d_reqs", idx), 32'(req_cnt - r0), 32'(vecs[idx].exp_reqs));
    check($sformatf("vec%0d_drained", idx), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int g;
    int c0;

    vecs[0] = '{32'h0000_0020, 2, 1};
    vecs[1] = '{32'h0000_0000, 1, 1};
    vecs[2] = '{32'h0000_0040, 1, 1};
    vecs[3] = '{32'h0000_0000, 1, 1};
    vecs[4] = '{32'h0000_0008, 3, 0};
    vecs[5] = '{32'hFFFF_FFF8, 4, 2};
    vecs[6] = '{32'h0000_0030, 2, 2};
    vecs[7] = '{32'h0000_0000, 6, 0};

    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    rob_full  = 1'b1;
    rs_full   = 1'b0;
    flush     = 1'b0;
    target_pc = '0;
    done      = 1'b0;
    mem_ins   = '0;
    repeat (3) @(negedge clk_in);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_dec_en", 32'(dec_en), 32'd0);
    check("rst_dec_ins", dec_ins, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    rst_in = 1'b0;

    // First fetch after reset, then the sequential miss at 4.
    exp_q.push_back(32'h0);
    wait_req(1);
    check("first_req_addr", last_req_addr, 32'h0);
    wait_idle();
    rob_full = 1'b0;
    wait_issues(1);
    rob_full = 1'b1;
    wait_req(2);
    check("second_req_addr", last_req_addr, 32'h4);
    wait_idle();
    exp_q.push_back(32'h4);
    rob_full = 1'b0;
    wait_issues(2);
    rob_full = 1'b1;

    // Lines 0,4,8 resident: back-to-back hits with no memory traffic.
    wait_idle();
    r0 = req_cnt;
    g  = issued;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    start_flush(32'h0);
    wait_issues(g + 1);
    c0 = issue_cyc;
    wait_issues(g + 3);
    rob_full = 1'b1;
    check("hits_no_req", 32'(req_cnt - r0), 32'd0);
    check("hits_back_to_back", 32'(issue_cyc - c0), 32'd2);

    // Stalls during a hit stream: rob_full for 5 cycles, then rs_full alone.
    wait_idle();
    g = issued;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    start_flush(32'h0);
    wait_issues(g + 2);
    rob_full = 1'b1;
    repeat (5) @(negedge clk_in);
    check("rob_stall_no_issue", 32'(issued), 32'(g + 2));
    exp_q.push_back(32'h8);
    rob_full = 1'b0;
    wait_issues(g + 3);
    rs_full = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rs_stall_no_issue", 32'(issued), 32'(g + 3));
    exp_q.push_back(32'hC);
    rs_full = 1'b0;
    wait_issues(g + 4);
    rob_full = 1'b1;
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Flush while missing on 0x20: line filled silently, then 0x100 fetched.
    wait_idle();
    r0 = req_cnt;
    g  = issued;
    start_flush(32'h20);
    wait_req(r0 + 1);
    check("drop_first_req", last_req_addr, 32'h20);
    exp_q.push_back(32'h100);
    flush     = 1'b1;
    target_pc = 32'h100;
    @(negedge clk_in);
    flush = 1'b0;
    wait_req(r0 + 2);
    check("drop_second_req", last_req_addr, 32'h100);
    check("drop_no_issue", 32'(issued), 32'(g));
    wait_issues(g + 1);
    rob_full = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // rdy_in low 4 cycles mid-stream.
    wait_idle();
    g = issued;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    start_flush(32'h0);
    wait_issues(g + 2);
    c0     = issue_cyc;
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check("frz_dec_en", 32'(dec_en), 32'd0);
      check("frz_dec_pc", dec_pc, 32'h4);
      check("frz_dec_ins", dec_ins, mem_word(32'h4));
      check("frz_mem_en", 32'(mem_en), 32'd0);
    end
    rdy_in = 1'b1;
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    wait_issues(g + 3);
    check("frz_resume_gap", 32'(issue_cyc - c0), 32'd5);
    wait_issues(g + 4);
    rob_full = 1'b1;
    repeat (3) @(negedge clk_in);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
